alu_control_sequencer: RTL and testbench

//  Driver end of the 4-bit ALUOperation interface: decodes control-unit ALUOp plus R-type funct

---
 rtl/alu_control_sequencer_pkg.sv | 71 +++++++
 rtl/alu_control_sequencer_mult_shift_add.sv | 74 +++++++
 rtl/alu_control_sequencer.sv | 115 +++++++++++
 tb/tb_alu_control_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_sequencer_pkg.sv
// rtl/alu_control_sequencer_pkg.sv - shared ALU op codes, control classes, funct codes, FSM states
// Purpose: single source of the 4-bit ALUOperation encoding and the decode rule used by the
//          control sequencer, the ALU and the main control unit.
// Ports:   none (package).
package alu_control_sequencer_pkg;

   // ALUOperation codes presented to the ALU
   localparam logic [3:0] OP_AND      = 4'b0000;
   localparam logic [3:0] OP_OR       = 4'b0001;
   localparam logic [3:0] OP_NOR      = 4'b0010;
   localparam logic [3:0] OP_ADD      = 4'b0011;
   localparam logic [3:0] OP_SUB      = 4'b0100;
   localparam logic [3:0] OP_INC      = 4'b0101;
   localparam logic [3:0] OP_MULTPLUS = 4'b0110;
   localparam logic [3:0] OP_NOP      = 4'b1111;

   // ALUOp class codes from the main control unit
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b010;
   localparam logic [2:0] ALUOP_OR    = 3'b011;
   localparam logic [2:0] ALUOP_AND   = 3'b100;
   localparam logic [2:0] ALUOP_INC   = 3'b101;

   // R-type funct field codes
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_MULT = 6'b011000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } seq_state_t;

   typedef struct packed {
      logic       illegal;
      logic [3:0] op;
   } decode_t;

   // Undecodable combinations resolve to NOP so the ALU produces 0 while Illegal is flagged.
   function automatic decode_t decode_op(input logic [2:0] alu_op, input logic [5:0] funct);
      decode_t d;
      d.illegal = 1'b0;
      d.op      = OP_NOP;
      case (alu_op)
         ALUOP_ADD: d.op = OP_ADD;
         ALUOP_SUB: d.op = OP_SUB;
         ALUOP_OR:  d.op = OP_OR;
         ALUOP_AND: d.op = OP_AND;
         ALUOP_INC: d.op = OP_INC;
         ALUOP_RTYPE: begin
            case (funct)
               FN_ADD:  d.op = OP_ADD;
               FN_SUB:  d.op = OP_SUB;
               FN_AND:  d.op = OP_AND;
               FN_OR:   d.op = OP_OR;
               FN_NOR:  d.op = OP_NOR;
               FN_MULT: d.op = OP_MULTPLUS;
               default: d.illegal = 1'b1;
            endcase
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_control_sequencer_mult_shift_add.sv
// rtl/alu_control_sequencer_mult_shift_add.sv - iterative shift-add multiplier with +1 on completion
// Purpose: computes ((A*B) mod 2^WIDTH) + 1 one partial product per stepped cycle.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_start        load operands, clear accumulator and counter
//   i_step         perform one shift-add iteration
//   i_a, i_b       operands, sampled on i_start
//   o_last         current step is the final iteration
//   o_done         1-cycle pulse, o_result updated
//   o_result       held result of the last completed multiply
module mult_shift_add
   import alu_control_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_done;
   logic [WIDTH-1:0] r_result;

   logic [WIDTH-1:0] w_acc_next;
   logic             w_last;

   assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
         end else if (i_step) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            // Final partial product folds straight into the result so it is ready with the pulse.
            if (w_last) begin
               r_done   <= 1'b1;
               r_result <= w_acc_next + {{(WIDTH-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign o_last   = w_last;
   assign o_done   = r_done;
   assign o_result = r_result;

endmodule

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - ALUOp/funct decoder with stalling shift-add multiply sequencer
// Purpose: drives the 4-bit ALUOperation to the execute-stage ALU; runs MULTPLUS locally over
//          WIDTH cycles while holding the pipeline via Stall.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   Issue          new instruction valid (accepted only in IDLE)
//   ALUOp          control-unit class code
//   ALUFunction    R-type funct field
//   A, B           multiply operands, sampled on an accepted MULTPLUS
//   ALUOperation   registered op code to the ALU
//   Illegal        1-cycle pulse for an undecodable ALUOp/funct
//   Stall          high while the multiply iterates
//   MulDone        1-cycle pulse, MulResult valid
//   MulResult      ((A*B) mod 2^WIDTH) + 1, held until next MulDone or reset
module alu_control_sequencer
   import alu_control_sequencer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Issue,
   input  logic [2:0]       ALUOp,
   input  logic [5:0]       ALUFunction,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [3:0]       ALUOperation,
   output logic             Illegal,
   output logic             Stall,
   output logic             MulDone,
   output logic [WIDTH-1:0] MulResult
);

   seq_state_t r_state;
   seq_state_t w_next_state;

   logic [3:0] r_alu_operation;
   logic       r_illegal;

   decode_t    w_dec;
   logic [3:0] w_op_d;
   logic       w_illegal_d;
   logic       w_start;
   logic       w_step;
   logic       w_last;

   assign w_dec = decode_op(ALUOp, ALUFunction);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_alu_operation <= OP_NOP;
         r_illegal       <= 1'b0;
      end else begin
         r_state         <= w_next_state;
         r_alu_operation <= w_op_d;
         r_illegal       <= w_illegal_d;
      end
   end

   // Issue outside IDLE (MUL or DONE) is dropped entirely: no decode, no Illegal pulse.
   always_comb begin
      w_next_state = r_state;
      w_op_d       = OP_NOP;
      w_illegal_d  = 1'b0;
      w_start      = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (Issue) begin
               if (!w_dec.illegal && (w_dec.op == OP_MULTPLUS)) begin
                  w_start      = 1'b1;
                  w_next_state = ST_MUL;
               end else begin
                  w_op_d      = w_dec.op;
                  w_illegal_d = w_dec.illegal;
               end
            end
         end
         ST_MUL: begin
            w_step = 1'b1;
            if (w_last) begin
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   mult_shift_add #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_mult (
      .clk      (clk),
      .reset    (reset),
      .i_start  (w_start),
      .i_step   (w_step),
      .i_a      (A),
      .i_b      (B),
      .o_last   (w_last),
      .o_done   (MulDone),
      .o_result (MulResult)
   );

   assign ALUOperation = r_alu_operation;
   assign Illegal      = r_illegal;
   assign Stall        = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - directed scoreboard bench for alu_control_sequencer
module tb_alu_control_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        Issue;
   logic [2:0]  ALUOp;
   logic [5:0]  ALUFunction;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUOperation;
   logic        Illegal;
   logic        Stall;
   logic        MulDone;
   logic [31:0] MulResult;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0]  dec_q[$];
   logic [31:0] mul_q[$];

   always #5 clk = ~clk;

   alu_control_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk          (clk),
      .reset        (reset),
      .Issue        (Issue),
      .ALUOp        (ALUOp),
      .ALUFunction  (ALUFunction),
      .A            (A),
      .B            (B),
      .ALUOperation (ALUOperation),
      .Illegal      (Illegal),
      .Stall        (Stall),
      .MulDone      (MulDone),
      .MulResult    (MulResult)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {illegal, op}
   function automatic logic [4:0] model_decode(input logic [2:0] op, input logic [5:0] fn);
      case (op)
         3'd0: return 5'b0_0011;
         3'd1: return 5'b0_0100;
         3'd3: return 5'b0_0001;
         3'd4: return 5'b0_0000;
         3'd5: return 5'b0_0101;
         3'd2: begin
            case (fn)
               6'h20:   return 5'b0_0011;
               6'h22:   return 5'b0_0100;
               6'h24:   return 5'b0_0000;
               6'h25:   return 5'b0_0001;
               6'h27:   return 5'b0_0010;
               6'h18:   return 5'b0_0110;
               default: return 5'b1_1111;
            endcase
         end
         default: return 5'b1_1111;
      endcase
   endfunction

   task automatic do_decode(input logic [2:0] op, input logic [5:0] fn, input string tag);
      logic [4:0] e;
      Issue = 1'b1;
      ALUOp = op;
      ALUFunction = fn;
      dec_q.push_back(model_decode(op, fn));
      tick;
      Issue = 1'b0;
      e = dec_q.pop_front();
      chk({tag, "_op"}, {28'd0, ALUOperation}, {28'd0, e[3:0]});
      chk({tag, "_ill"}, {31'd0, Illegal}, {31'd0, e[4]});
      chk({tag, "_stall"}, {31'd0, Stall}, 32'd0);
      tick;
      chk({tag, "_nop_after"}, {28'd0, ALUOperation}, 32'hF);
      chk({tag, "_ill_pulse"}, {31'd0, Illegal}, 32'd0);
   endtask

   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int intrude_at,
                         input bit issue_in_done, input string tag);
      int k;
      logic [31:0] e;
      Issue = 1'b1;
      ALUOp = 3'b010;
      ALUFunction = 6'b011000;
      A = a;
      B = b;
      mul_q.push_back(a * b + 32'd1);
      tick;
      Issue = 1'b0;
      A = $urandom;
      B = $urandom;
      k = 1;
      while (!MulDone && k < 100) begin
         chk({tag, "_stall"}, {31'd0, Stall}, 32'd1);
         chk({tag, "_nop_busy"}, {28'd0, ALUOperation}, 32'hF);
         Issue = (k == intrude_at);
         ALUOp = 3'b000;
         tick;
         Issue = 1'b0;
         k++;
      end
      chk({tag, "_latency"}, k, 32'd33);
      e = mul_q.pop_front();
      chk({tag, "_result"}, MulResult, e);
      chk({tag, "_stall_done"}, {31'd0, Stall}, 32'd0);
      if (issue_in_done) begin
         Issue = 1'b1;
         ALUOp = 3'b000;
      end
      tick;
      Issue = 1'b0;
      chk({tag, "_done_issue_ignored"}, {28'd0, ALUOperation}, 32'hF);
      chk({tag, "_done_pulse"}, {31'd0, MulDone}, 32'd0);
      chk({tag, "_result_hold"}, MulResult, e);
   endtask

   initial begin
      int seen;
      reset = 1'b1;
      Issue = 1'b0;
      ALUOp = 3'b000;
      ALUFunction = 6'b000000;
      A = 32'd0;
      B = 32'd0;
      tick;
      tick;
      chk("rst_op", {28'd0, ALUOperation}, 32'hF);
      chk("rst_ill", {31'd0, Illegal}, 32'd0);
      chk("rst_stall", {31'd0, Stall}, 32'd0);
      chk("rst_muldone", {31'd0, MulDone}, 32'd0);
      chk("rst_result", MulResult, 32'd0);
      reset = 1'b0;
      tick;
      chk("idle_nop", {28'd0, ALUOperation}, 32'hF);

      do_decode(3'b000, 6'b000000, "aluop_add");
      do_decode(3'b001, 6'b000000, "aluop_sub");
      do_decode(3'b011, 6'b000000, "aluop_or");
      do_decode(3'b100, 6'b000000, "aluop_and");
      do_decode(3'b101, 6'b000000, "aluop_inc");
      do_decode(3'b010, 6'b100000, "r_add");
      do_decode(3'b010, 6'b100010, "r_sub");
      do_decode(3'b010, 6'b100100, "r_and");
      do_decode(3'b010, 6'b100101, "r_or");
      do_decode(3'b010, 6'b100111, "r_nor");
      do_decode(3'b010, 6'b111111, "r_bad");
      do_decode(3'b110, 6'b100000, "aluop_110");
      do_decode(3'b111, 6'b100000, "aluop_111");

      do_mul(32'd3, 32'd5, 5, 1'b1, "mul_3x5");
      do_decode(3'b001, 6'b000000, "after_mul_sub");
      do_mul(32'hFFFF_FFFF, 32'd1, 0, 1'b0, "mul_wrap");
      do_mul(32'h0001_0000, 32'h0001_0000, 0, 1'b0, "mul_ovf");
      do_mul($urandom, $urandom, 17, 1'b1, "mul_rand");

      // Reset mid-multiply: abort with no MulDone, then accept new work.
      Issue = 1'b1;
      ALUOp = 3'b010;
      ALUFunction = 6'b011000;
      A = 32'd7;
      B = 32'd9;
      tick;
      Issue = 1'b0;
      for (int i = 0; i < 9; i++) tick;
      chk("pre_rst_stall", {31'd0, Stall}, 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mrst_op", {28'd0, ALUOperation}, 32'hF);
      chk("mrst_ill", {31'd0, Illegal}, 32'd0);
      chk("mrst_stall", {31'd0, Stall}, 32'd0);
      chk("mrst_muldone", {31'd0, MulDone}, 32'd0);
      chk("mrst_result", MulResult, 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (MulDone) seen++;
         tick;
      end
      chk("mrst_no_muldone", seen, 32'd0);
      do_decode(3'b010, 6'b100111, "post_rst_nor");
      do_mul(32'd12, 32'd12, 0, 1'b0, "post_rst_mul");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
